theia: RTL and testbench

- Minimal single-core slice of the Theia ray-cast GPU.
- A byte-oriented UART host port lets the host write and read a 32-bit control register and the memories of one AABB execution unit, AABB0.
- AABB0 has a 32-bit data RAM (register file) and a 32-bit instruction RAM.
- The host triggers AABB0 through the control register; AABB0 executes instructions until it hits a STOP or BREAK instruction.

---
 rtl/theia.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_theia.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/theia.sv
// theia: single-core slice of the Theia ray-cast GPU.
// A byte-oriented UART host port reads and writes a control register and the
// data / instruction RAMs of one AABB execution unit (AABB0). The host starts
// AABB0 through the control register; it runs until a STOP or BREAK.
module theia #(
    parameter int DATA_DEPTH = 16,
    parameter int INSN_DEPTH = 16,
    parameter int TX_GAP     = 16
) (
    input  logic       iGlobalClock,
    input  logic       iGlobalReset,
    input  logic       iUartByteAvailable,
    input  logic [7:0] iUartRx,
    output logic       oUartTxByteAvailable,
    output logic [7:0] oUartTx
);

    localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int IW = (INSN_DEPTH > 1) ? $clog2(INSN_DEPTH) : 1;
    localparam int GW = $clog2(TX_GAP + 1);

    typedef enum logic [3:0] {
        H_CMD, H_DEV, H_AH, H_AL, H_D3, H_D2, H_D1, H_D0, H_WR, H_TX
    } host_state_e;

    typedef enum logic [1:0] {
        C_IDLE, C_FETCH, C_EXEC
    } core_state_e;

    logic clk;
    logic rst_n;
    assign clk   = iGlobalClock;
    assign rst_n = iGlobalReset;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] dmem [DATA_DEPTH];
    logic [31:0] imem [INSN_DEPTH];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              avail_q, avail_prev_q;
    logic [7:0]        rx_q;
    host_state_e       hstate_q, hstate_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        dev_q, dev_d;
    logic [15:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic [GW-1:0]     tx_timer_q, tx_timer_d;
    logic [31:0]       tx_word_q, tx_word_d;
    logic              tx_stb_q, tx_stb_d;
    logic [7:0]        tx_byte_q, tx_byte_d;

    core_state_e       cstate_q, cstate_d;
    logic [IW-1:0]     pc_q, pc_d;
    logic [31:0]       insn_q, insn_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;

    // Cross-FSM strobes and write enables
    logic              byte_stb;
    logic              busy;
    logic              host_start, host_pc_clr;
    logic              dmem_host_we, imem_host_we;
    logic              dmem_core_we;
    logic [31:0]       core_result;
    logic [31:0]       rd_word;
    logic [31:0]       fetch_insn;
    logic [IW-1:0]     pc_inc;

    assign byte_stb   = avail_q & ~avail_prev_q;
    assign busy       = (cstate_q != C_IDLE);
    assign fetch_insn = imem[pc_q];
    assign pc_inc     = (pc_q == IW'(INSN_DEPTH - 1)) ? '0 : pc_q + 1'b1;

    assign oUartTxByteAvailable = tx_stb_q;
    assign oUartTx              = tx_byte_q;

    // Address bits above the RAM index and reserved instruction fields
    logic unused_ok;
    assign unused_ok = ^{addr_q, insn_q, fetch_insn};

    // Register the host strobe and byte, keeping one delayed copy for edge detect
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avail_q      <= 1'b0;
            avail_prev_q <= 1'b0;
            rx_q         <= '0;
        end else begin
            avail_q      <= iUartByteAvailable;
            avail_prev_q <= avail_q;
            rx_q         <= iUartRx;
        end
    end

    // Host-visible read value for the currently addressed device
    always_comb begin
        rd_word = '0;
        case (dev_q)
            8'h00:   rd_word = {busy, 23'b0, 8'(pc_q)};
            8'h01:   rd_word = dmem[addr_q[AW-1:0]];
            8'h02:   rd_word = imem[addr_q[IW-1:0]];
            default: rd_word = '0;
        endcase
    end

    // Host protocol: command / device / address bytes, then data in or response out
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        hstate_d     = hstate_q;
        is_wr_d      = is_wr_q;
        dev_d        = dev_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tx_idx_d     = tx_idx_q;
        tx_timer_d   = tx_timer_q;
        tx_word_d    = tx_word_q;
        tx_stb_d     = 1'b0;
        tx_byte_d    = tx_byte_q;
        host_start   = 1'b0;
        host_pc_clr  = 1'b0;
        dmem_host_we = 1'b0;
        imem_host_we = 1'b0;

        case (hstate_q)
            H_CMD: if (byte_stb) begin
                is_wr_d  = rx_q[7];
                hstate_d = H_DEV;
            end
            H_DEV: if (byte_stb) begin
                dev_d    = rx_q;
                hstate_d = H_AH;
            end
            H_AH: if (byte_stb) begin
                addr_d[15:8] = rx_q;
                hstate_d     = H_AL;
            end
            H_AL: if (byte_stb) begin
                addr_d[7:0] = rx_q;
                tx_idx_d    = '0;
                tx_timer_d  = '0;
                hstate_d    = is_wr_q ? H_D3 : H_TX;
            end
            H_D3, H_D2, H_D1, H_D0: if (byte_stb) begin
                wdata_d = {wdata_q[23:0], rx_q};
                case (hstate_q)
                    H_D3:    hstate_d = H_D2;
                    H_D2:    hstate_d = H_D1;
                    H_D1:    hstate_d = H_D0;
                    default: hstate_d = H_WR;
                endcase
            end
            H_WR: begin
                case (dev_q)
                    8'h00: begin
                        host_start  = wdata_q[31] && (cstate_q == C_IDLE);
                        host_pc_clr = wdata_q[0];
                    end
                    8'h01:   dmem_host_we = !busy;
                    8'h02:   imem_host_we = !busy;
                    default: ;
                endcase
                hstate_d = H_CMD;
            end
            H_TX: begin
                if (tx_timer_q == '0) begin
                    logic [31:0] word;
                    // First byte snapshots the word so all four bytes are coherent
                    word = (tx_idx_q == 2'd0) ? rd_word : tx_word_q;
                    tx_word_d = word;
                    tx_stb_d  = 1'b1;
                    case (tx_idx_q)
                        2'd0:    tx_byte_d = word[31:24];
                        2'd1:    tx_byte_d = word[23:16];
                        2'd2:    tx_byte_d = word[15:8];
                        default: tx_byte_d = word[7:0];
                    endcase
                    if (tx_idx_q == 2'd3) begin
                        hstate_d = H_CMD;
                    end else begin
                        tx_idx_d   = tx_idx_q + 2'd1;
                        tx_timer_d = GW'(TX_GAP - 1);
                    end
                end else begin
                    tx_timer_d = tx_timer_q - 1'b1;
                end
            end
            default: hstate_d = H_CMD;
        endcase
    end

    // Host FSM registers and registered UART outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hstate_q   <= H_CMD;
            is_wr_q    <= 1'b0;
            dev_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_idx_q   <= '0;
            tx_timer_q <= '0;
            tx_word_q  <= '0;
            tx_stb_q   <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            hstate_q   <= hstate_d;
            is_wr_q    <= is_wr_d;
            dev_q      <= dev_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_idx_q   <= tx_idx_d;
            tx_timer_q <= tx_timer_d;
            tx_word_q  <= tx_word_d;
            tx_stb_q   <= tx_stb_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Core sequencing: fetch instruction and operands, then execute and advance PC
    always_comb begin
        cstate_d     = cstate_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        dmem_core_we = 1'b0;
        core_result  = '0;

        case (cstate_q)
            C_IDLE: if (host_start) cstate_d = C_FETCH;
            C_FETCH: begin
                insn_d   = fetch_insn;
                op_a_d   = dmem[fetch_insn[8 +: AW]];
                op_b_d   = dmem[fetch_insn[16 +: AW]];
                cstate_d = C_EXEC;
            end
            C_EXEC: begin
                case (insn_q[27:24])
                    4'd1: begin core_result = op_a_q + op_b_q; dmem_core_we = 1'b1; end
                    4'd2: begin core_result = op_a_q - op_b_q; dmem_core_we = 1'b1; end
                    4'd3: begin core_result = op_a_q & op_b_q; dmem_core_we = 1'b1; end
                    4'd4: begin core_result = op_a_q | op_b_q; dmem_core_we = 1'b1; end
                    default: ;
                endcase
                if (insn_q[31]) begin
                    pc_d     = '0;
                    cstate_d = C_IDLE;
                end else if (insn_q[30]) begin
                    pc_d     = pc_inc;
                    cstate_d = C_IDLE;
                end else begin
                    pc_d     = pc_inc;
                    cstate_d = C_FETCH;
                end
            end
            default: cstate_d = C_IDLE;
        endcase

        // A host PC clear wins, so start+clear begins at PC 0
        if (host_pc_clr) pc_d = '0;
    end

    // Core FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstate_q <= C_IDLE;
            pc_q     <= '0;
            insn_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            cstate_q <= cstate_d;
            pc_q     <= pc_d;
            insn_q   <= insn_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
        end
    end

    // RAM write ports: core write-back, or host writes while the core is idle
    // NOTE: RAM contents are deliberately not reset; reset only returns the core to IDLE.
    always_ff @(posedge clk) begin
        if (dmem_core_we) begin
            dmem[insn_q[AW-1:0]] <= core_result;
        end else if (dmem_host_we) begin
            dmem[addr_q[AW-1:0]] <= wdata_q;
        end
        if (imem_host_we) begin
            imem[addr_q[IW-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_theia.sv
// Self-checking bench for theia: drives the UART host protocol and checks every
// response byte against a scoreboard filled when each read is issued.
module tb_theia;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       avail = 1'b0;
    logic [7:0] rx    = '0;
    logic       tx_stb;
    logic [7:0] tx;

    always #5 clk = ~clk;

    theia dut (
        .iGlobalClock         (clk),
        .iGlobalReset         (rst_n),
        .iUartByteAvailable   (avail),
        .iUartRx              (rx),
        .oUartTxByteAvailable (tx_stb),
        .oUartTx              (tx)
    );

    typedef struct packed {
        logic [7:0] exp;
        logic [7:0] mask;
    } sb_t;

    sb_t   sb_q[$];
    string cur_name = "none";
    int    n_checks = 0;
    int    n_fail   = 0;

    // Response monitor: pop one expected byte per strobe
    always @(negedge clk) begin
        if (rst_n && tx_stb === 1'b1) begin
            sb_t e;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tx: got %02h with no byte expected", tx);
            end else begin
                e = sb_q.pop_front();
                if ((tx & e.mask) !== (e.exp & e.mask)) begin
                    n_fail++;
                    $display("FAIL %s: got byte %02h, expected %02h (mask %02h)",
                             cur_name, tx, e.exp, e.mask);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx    = b;
        avail = 1'b1;
        repeat (hold) @(negedge clk);
        avail = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic host_write(input logic [7:0] dev, input logic [15:0] addr,
                              input logic [31:0] data, input int hold);
        send_byte(8'h80, hold);
        send_byte(dev, hold);
        send_byte(addr[15:8], hold);
        send_byte(addr[7:0], hold);
        send_byte(data[31:24], hold);
        send_byte(data[23:16], hold);
        send_byte(data[15:8], hold);
        send_byte(data[7:0], hold);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d bytes outstanding, expected 0", cur_name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic host_read(input string name, input logic [7:0] dev, input logic [15:0] addr,
                             input logic [31:0] exp, input logic [31:0] mask);
        sb_t e;
        cur_name = name;
        for (int k = 3; k >= 0; k--) begin
            e.exp  = exp[8*k +: 8];
            e.mask = mask[8*k +: 8];
            sb_q.push_back(e);
        end
        send_byte(8'h00, 2);
        send_byte(dev, 2);
        send_byte(addr[15:8], 2);
        send_byte(addr[7:0], 2);
        wait_drain();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tx_stb: got %b, expected 0", tx_stb);
        end
        n_checks++;
        if (tx !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_byte: got %02h, expected 00", tx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        host_read("reset_ctrl", 8'h00, 16'h0000, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_program();
        host_write(8'h01, 16'h0000, 32'd6, 2);
        host_write(8'h01, 16'h0001, 32'd8, 2);
        host_write(8'h01, 16'h0002, 32'd10, 2);
        host_write(8'h01, 16'h0003, 32'd7, 2);
        host_write(8'h01, 16'h0004, 32'd0, 2);
        host_write(8'h01, 16'h0005, 32'd0, 2);
        host_write(8'h02, 16'h0000, 32'h0200_0102, 2);  // R2 = R1 - R0
        host_write(8'h02, 16'h0001, 32'h0205_0203, 2);  // R3 = R2 - R5
        host_write(8'h02, 16'h0002, 32'h8000_0000, 2);  // STOP
        host_write(8'h00, 16'h0000, 32'h8000_0000, 2);
        repeat (20) @(negedge clk);
        host_read("prog_r2", 8'h01, 16'h0002, 32'd2, 32'hFFFF_FFFF);
        host_read("prog_r3", 8'h01, 16'h0003, 32'd2, 32'hFFFF_FFFF);
        host_read("prog_r1", 8'h01, 16'h0001, 32'd8, 32'hFFFF_FFFF);
        host_read("prog_r4", 8'h01, 16'h0004, 32'd0, 32'hFFFF_FFFF);
        host_read("prog_ctrl", 8'h00, 16'h0000, 32'h0, 32'hFFFF_FFFF);
        host_read("prog_insn0", 8'h02, 16'h0000, 32'h0200_0102, 32'hFFFF_FFFF);
    endtask

    task automatic test_idempotent();
        host_write(8'h00, 16'h0000, 32'h0000_0000, 2);
        host_write(8'h00, 16'h0000, 32'h8000_0000, 10);  // long strobes
        repeat (20) @(negedge clk);
        host_read("idem_r2", 8'h01, 16'h0002, 32'd2, 32'hFFFF_FFFF);
        host_read("idem_r3", 8'h01, 16'h0003, 32'd2, 32'hFFFF_FFFF);
        host_read("idem_ctrl", 8'h00, 16'h0000, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_break();
        host_write(8'h02, 16'h0000, 32'h4200_0102, 2);  // BREAK + SUB
        host_write(8'h00, 16'h0000, 32'h8000_0000, 2);
        repeat (20) @(negedge clk);
        host_read("break_pc1", 8'h00, 16'h0000, 32'h0000_0001, 32'hFFFF_FFFF);
        host_write(8'h00, 16'h0000, 32'h8000_0000, 2);
        repeat (20) @(negedge clk);
        host_read("break_resume_pc0", 8'h00, 16'h0000, 32'h0, 32'hFFFF_FFFF);
        host_read("break_r3", 8'h01, 16'h0003, 32'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_pc_wrap();
        for (int i = 0; i < 16; i++) host_write(8'h02, 16'(i), 32'h0, 2);
        host_write(8'h01, 16'h0008, 32'h11, 2);
        host_write(8'h02, 16'h000E, 32'h4000_0000, 2);  // BREAK at 14
        host_write(8'h02, 16'h000F, 32'h0108_0809, 2);  // R9 = R8 + R8
        host_write(8'h00, 16'h0000, 32'h8000_0001, 2);  // start + clear
        repeat (50) @(negedge clk);
        host_read("wrap_pc15", 8'h00, 16'h0000, 32'h0000_000F, 32'hFFFF_FFFF);
        host_write(8'h02, 16'h0000, 32'h4000_0000, 2);  // BREAK at 0
        host_write(8'h00, 16'h0000, 32'h8000_0000, 2);
        repeat (20) @(negedge clk);
        host_read("wrap_pc1", 8'h00, 16'h0000, 32'h0000_0001, 32'hFFFF_FFFF);
        host_read("wrap_r9", 8'h01, 16'h0009, 32'h22, 32'hFFFF_FFFF);
    endtask

    task automatic test_busy_drop();
        for (int i = 0; i < 16; i++) host_write(8'h02, 16'(i), 32'h0, 2);  // endless NOPs
        host_write(8'h00, 16'h0000, 32'h8000_0001, 2);
        host_write(8'h01, 16'h0008, 32'hDEAD_BEEF, 2);
        host_write(8'h07, 16'h0000, 32'h1234_5678, 2);
        host_read("busy_r8_kept", 8'h01, 16'h0008, 32'h11, 32'hFFFF_FFFF);
        host_read("bad_dev_read", 8'h07, 16'h0000, 32'h0, 32'hFFFF_FFFF);
        host_read("busy_flag", 8'h00, 16'h0000, 32'h8000_0000, 32'hFFFF_FFF0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_tx_stb: got %b, expected 0", tx_stb);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        host_read("midreset_ctrl", 8'h00, 16'h0000, 32'h0, 32'hFFFF_FFFF);
        host_read("midreset_r8", 8'h01, 16'h0008, 32'h11, 32'hFFFF_FFFF);
        host_read("midreset_r2", 8'h01, 16'h0002, 32'd2, 32'hFFFF_FFFF);
    endtask

    initial begin
        test_reset();
        test_program();
        test_idempotent();
        test_break();
        test_pc_wrap();
        test_busy_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
